// File: rtl/icache_fill_unit_pkg.sv
// ============================================================================
//  Module      : icache_fill_unit_pkg
//  Description : Shared types and constants for the L1I miss/fill responder:
//                fill FSM encoding, miss-entry layout and beat count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_fill_unit_pkg;

    // Default geometry (the top-level parameters default to these values)
    localparam int c_ADDR_W      = 64;
    localparam int c_LINE_W      = 512;
    localparam int c_OFFSET_W    = 6;
    localparam int c_BEAT_W      = 128;
    localparam int c_PID_W       = 20;
    localparam int c_TID_W       = 16;
    localparam int c_IC_W        = 64;
    localparam int c_QUEUE_DEPTH = 4;

    // Memory beats needed to assemble one cache line
    localparam int BEATS_PER_LINE = c_LINE_W / c_BEAT_W;

    // Fill sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_COLLECT = 2'd2,
        S_UPDATE  = 2'd3
    } fill_state_t;

    // One queued miss; the line address sits in the most significant field
    // so the queue can compare it without knowing the other fields.
    typedef struct packed {
        logic [c_ADDR_W-1:0] line_addr;
        logic [c_IC_W-1:0]   major_id;
        logic [c_PID_W-1:0]  pid;
        logic [c_TID_W-1:0]  tid;
    } miss_entry_t;

    localparam int c_MISS_ENTRY_W = $bits(miss_entry_t);

endpackage : icache_fill_unit_pkg

`default_nettype wire

// File: rtl/icache_fill_unit_miss_queue.sv
// ============================================================================
//  Module      : miss_queue
//  Description : Power-of-two deep FIFO of miss entries with full/empty/count.
//                The top KEY_W bits of each entry are its line address; with
//                ICACHE_FILL_MERGE_EN defined the queue also reports which
//                valid entries hold a given line address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module miss_queue #(
    parameter int DATA_W = 164,
    parameter int KEY_W  = 64,
    parameter int DEPTH  = 4    // power of two, at least 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [KEY_W-1:0]         o_head_key,
    output logic [DATA_W-KEY_W-1:0]  o_head_rest,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef ICACHE_FILL_MERGE_EN
    ,
    input  logic [KEY_W-1:0]         i_match_key,
    output logic [DEPTH-1:0]         o_match
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full      = (r_count == c_CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_key  = r_mem[r_rd_ptr][DATA_W-1 -: KEY_W];
    assign o_head_rest = r_mem[r_rd_ptr][DATA_W-KEY_W-1:0];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Entry storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ICACHE_FILL_MERGE_EN
    logic [c_PTR_W-1:0] w_rel;

    // Slot i is live when its distance from the head is below the count
    always_comb begin
        o_match = '0;
        w_rel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel = c_PTR_W'(i) - r_rd_ptr;
            if (({1'b0, w_rel} < r_count) &&
                (r_mem[i][DATA_W-1 -: KEY_W] == i_match_key)) begin
                o_match[i] = 1'b1;
            end
        end
    end
`endif

endmodule : miss_queue

`default_nettype wire

// File: rtl/icache_fill_unit.sv
// ============================================================================
//  Module      : icache_fill_unit
//  Description : L1 instruction-cache miss responder. Queues fetch misses,
//                requests each 64-byte line from the next level, assembles
//                the returned beats and drives the cache-update port.
//                Optional macro ICACHE_FILL_MERGE_EN absorbs misses to a
//                line that is already queued or in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fill_unit
    import icache_fill_unit_pkg::*;
#(
    parameter int fetchingAddressWidth    = c_ADDR_W,
    parameter int cacheLineWidth          = c_LINE_W,
    parameter int offsetWidth             = c_OFFSET_W,
    parameter int beatWidth               = c_BEAT_W,
    parameter int PidSize                 = c_PID_W,
    parameter int TidSize                 = c_TID_W,
    parameter int instructionCounterWidth = c_IC_W,
    parameter int queueDepth              = c_QUEUE_DEPTH
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    // Miss requests from the fetch unit
    input  logic                                 cacheMiss_i,
    input  logic [0:fetchingAddressWidth-1]      missedAddress_i,
    input  logic [0:instructionCounterWidth-1]   missedInstMajorId_i,
    input  logic [0:PidSize-1]                   missedPid_i,
    input  logic [0:TidSize-1]                   missedTid_i,
    output logic                                 missQueueFull_o,
    output logic                                 missDropped_o,
    // Next-level memory request/response
    output logic                                 memReqValid_o,
    input  logic                                 memReqReady_i,
    output logic [0:fetchingAddressWidth-1]      memReqAddress_o,
    input  logic                                 memRespValid_i,
    input  logic [0:beatWidth-1]                 memRespData_i,
    // Line fill towards the L1I
    output logic                                 cacheUpdate_o,
    output logic [0:fetchingAddressWidth-1]      cacheUpdateAddress_o,
    output logic [0:PidSize-1]                   cacheUpdatePid_o,
    output logic [0:TidSize-1]                   cacheUpdateTid_o,
    output logic [0:instructionCounterWidth-1]   missedInstMajorId_o,
    output logic [0:cacheLineWidth-1]            cacheUpdateLine_o
);

    localparam int c_REST_W    = instructionCounterWidth + PidSize + TidSize;
    localparam int c_ENTRY_W   = fetchingAddressWidth + c_REST_W;
    localparam int c_BEATS     = cacheLineWidth / beatWidth;
    localparam int c_BEAT_CW   = $clog2(c_BEATS);
    localparam int c_CNT_W     = $clog2(queueDepth) + 1;
    localparam logic [c_BEAT_CW-1:0] c_LAST_BEAT = c_BEAT_CW'(c_BEATS - 1);
    localparam logic [0:fetchingAddressWidth-1] c_LINE_MASK =
        {fetchingAddressWidth{1'b1}} << offsetWidth;

    fill_state_t                        r_state;
    logic [c_BEAT_CW-1:0]               r_beat;
    logic [0:cacheLineWidth-1]          r_line;

    logic [0:fetchingAddressWidth-1]    w_miss_line;
    logic [c_ENTRY_W-1:0]               w_entry;
    logic [fetchingAddressWidth-1:0]    w_head_addr;
    logic [c_REST_W-1:0]                w_head_rest;
    logic [0:instructionCounterWidth-1] w_head_major;
    logic [0:PidSize-1]                 w_head_pid;
    logic [0:TidSize-1]                 w_head_tid;
    logic                               w_full;
    logic                               w_empty;
    logic [c_CNT_W-1:0]                 w_count;
    logic                               w_full_pre;
    logic                               w_merge;
    logic                               w_push;
    logic                               w_drop;
    logic                               w_pop;
    logic [0:cacheLineWidth-1]          w_line_next;

    assign w_miss_line = missedAddress_i & c_LINE_MASK;
    assign w_entry     = {w_miss_line, missedInstMajorId_i, missedPid_i, missedTid_i};

    assign w_head_major = w_head_rest[c_REST_W-1 -: instructionCounterWidth];
    assign w_head_pid   = w_head_rest[TidSize +: PidSize];
    assign w_head_tid   = w_head_rest[0 +: TidSize];

    // Admission is decided on the count held before this cycle's pop, so a
    // full queue drops a miss even while its head is being retired.
    assign w_full_pre = (w_count == c_CNT_W'(queueDepth));
    assign w_push     = cacheMiss_i && !w_merge && !w_full_pre;
    assign w_drop     = cacheMiss_i && !w_merge && w_full_pre;
    assign w_pop      = (r_state == S_UPDATE);

    assign missQueueFull_o = w_full;

`ifdef ICACHE_FILL_MERGE_EN
    logic [queueDepth-1:0] w_match;
    assign w_merge = cacheMiss_i && (|w_match);
`else
    assign w_merge = 1'b0;
`endif

    miss_queue #(
        .DATA_W (c_ENTRY_W),
        .KEY_W  (fetchingAddressWidth),
        .DEPTH  (queueDepth)
    ) u_miss_queue (
        .clk         (clock_i),
        .rst_n       (reset_i),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (w_entry),
        .o_head_key  (w_head_addr),
        .o_head_rest (w_head_rest),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
`ifdef ICACHE_FILL_MERGE_EN
        ,
        .i_match_key (w_miss_line),
        .o_match     (w_match)
`endif
    );

    // Line image with the current beat merged in; beat 0 lands in the MSBs
    always_comb begin
        w_line_next = r_line;
        w_line_next[int'(r_beat) * beatWidth +: beatWidth] = memRespData_i;
    end

    // Fill sequencer with registered request/update outputs
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state              <= S_IDLE;
            r_beat               <= '0;
            r_line               <= '0;
            missDropped_o        <= 1'b0;
            memReqValid_o        <= 1'b0;
            memReqAddress_o      <= '0;
            cacheUpdate_o        <= 1'b0;
            cacheUpdateAddress_o <= '0;
            cacheUpdatePid_o     <= '0;
            cacheUpdateTid_o     <= '0;
            missedInstMajorId_o  <= '0;
            cacheUpdateLine_o    <= '0;
        end else begin
            missDropped_o <= w_drop;
            cacheUpdate_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state         <= S_REQ;
                        memReqValid_o   <= 1'b1;
                        memReqAddress_o <= w_head_addr;
                    end
                end
                S_REQ: begin
                    if (memReqReady_i) begin
                        r_state       <= S_COLLECT;
                        memReqValid_o <= 1'b0;
                        r_beat        <= '0;
                    end
                end
                S_COLLECT: begin
                    if (memRespValid_i) begin
                        r_line <= w_line_next;
                        r_beat <= r_beat + c_BEAT_CW'(1);
                        if (r_beat == c_LAST_BEAT) begin
                            r_state              <= S_UPDATE;
                            cacheUpdate_o        <= 1'b1;
                            cacheUpdateAddress_o <= w_head_addr;
                            cacheUpdatePid_o     <= w_head_pid;
                            cacheUpdateTid_o     <= w_head_tid;
                            missedInstMajorId_o  <= w_head_major;
                            cacheUpdateLine_o    <= w_line_next;
                        end
                    end
                end
                S_UPDATE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : icache_fill_unit

`default_nettype wire
